soft_recursion_scheduler: RTL and testbench

- Sequences strands through the soft forward/backward recursion engine (the alpha/beta matrix block).
- Queues incoming (strand, N, tag) jobs in a small FIFO and issues a one-cycle start pulse for each job.
- Holds the engine's strand/N inputs stable while the engine runs and while a downstream consumer reads alpha/beta.
- Releases the engine for the next job only after the consumer acknowledges.

---
 rtl/soft_recursion_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_soft_recursion_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soft_recursion_scheduler.sv
// soft_recursion_scheduler
// Queues (strand, N, tag) jobs for the soft forward/backward recursion engine,
// launches each job with a one-cycle start pulse, holds the engine inputs
// steady while the engine runs and while the consumer reads alpha/beta, and
// only moves on once the consumer acknowledges.
//
// Optional feature: define SOFT_REC_WATCHDOG_EN to add a run-time watchdog
// and the extra 'timeout' output.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          job handshake
//   in_strand, in_len, in_tag  job payload (received strand, post-IDS length N, id)
//   eng_start                  one-cycle start pulse to the engine
//   eng_strand, eng_N          engine inputs, stable from pop until HOLD exits
//   eng_done                   engine done level (stale until the engine clears it)
//   res_valid, res_tag         current job's results are readable
//   res_ack                    consumer done reading (only honoured in HOLD)
//   err_len                    one-cycle pulse: job dropped for illegal length
//   busy                       FSM active or jobs still queued
//   jobs_done                  completed-job counter, wraps
//   timeout                    (watchdog build only) result produced by watchdog
//
// States:
//   IDLE   | waiting for a queued job; pops and latches it when one is present
//   LAUNCH | eng_start asserted for this single cycle
//   ARM    | one-cycle blanking of the stale eng_done level
//   RUN    | waiting for eng_done
//   HOLD   | res_valid asserted until res_ack

module soft_recursion_scheduler #(
    parameter int DATA_WIDTH     = 32,
    parameter int n              = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_strand,
    input  logic [31:0]           in_len,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  eng_start,
    output logic [DATA_WIDTH-1:0] eng_strand,
    output logic [31:0]           eng_N,
    input  logic                  eng_done,
    output logic                  res_valid,
    output logic [TAG_WIDTH-1:0]  res_tag,
    input  logic                  res_ack,
    output logic                  err_len,
    output logic                  busy,
    output logic [15:0]           jobs_done
`ifdef SOFT_REC_WATCHDOG_EN
    ,
    output logic                  timeout
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] LIM_DW = 32'(DATA_WIDTH);
    localparam logic [31:0] LIM_N  = 32'(3 * n);

    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        ARM    = 3'd2,
        RUN    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t state_q, state_d;

    // ---------------- job FIFO ----------------
    logic [DATA_WIDTH-1:0] strand_mem [FIFO_DEPTH];
    logic [31:0]           len_mem    [FIFO_DEPTH];
    logic [TAG_WIDTH-1:0]  tag_mem    [FIFO_DEPTH];

    // One extra pointer bit distinguishes full from empty.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty, fifo_full;
    logic        len_ok, hs, push, pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign len_ok = (in_len != 32'd0) && (in_len <= LIM_DW) && (in_len <= LIM_N);
    assign in_ready = !fifo_full;
    assign hs       = in_valid && in_ready;
    assign push     = hs && len_ok;
    assign pop      = (state_q == IDLE) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            strand_mem[wr_ptr_q[AW-1:0]] <= in_strand;
            len_mem[wr_ptr_q[AW-1:0]]    <= in_len;
            tag_mem[wr_ptr_q[AW-1:0]]    <= in_tag;
        end
    end

    // ---------------- FSM ----------------
    logic complete;
`ifdef SOFT_REC_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;
    logic          wd_fire;
    logic          timeout_q;
`endif

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
`ifdef SOFT_REC_WATCHDOG_EN
        wd_fire  = 1'b0;
`endif
        unique case (state_q)
            IDLE:   if (!fifo_empty) state_d = LAUNCH;
            LAUNCH: state_d = ARM;
            ARM:    state_d = RUN;
            RUN: begin
                if (eng_done) begin
                    state_d  = HOLD;
                    complete = 1'b1;
                end
`ifdef SOFT_REC_WATCHDOG_EN
                else if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = HOLD;
                    wd_fire = 1'b1;
                end
`endif
            end
            HOLD:   if (res_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef SOFT_REC_WATCHDOG_EN
    // Counts cycles spent in ARM/RUN; zero on ARM entry.
    always_comb begin
        wd_cnt_d = '0;
        if (state_q == ARM || state_q == RUN) wd_cnt_d = wd_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            if (wd_fire)
                timeout_q <= 1'b1;
            else if (state_q == HOLD && res_ack)
                timeout_q <= 1'b0;
        end
    end

    assign timeout = timeout_q;
`endif

    logic [DATA_WIDTH-1:0] eng_strand_q;
    logic [31:0]           eng_n_q;
    logic [TAG_WIDTH-1:0]  res_tag_q;
    logic [15:0]           jobs_done_q;
    logic                  err_len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            eng_strand_q <= '0;
            eng_n_q      <= '0;
            res_tag_q    <= '0;
            jobs_done_q  <= '0;
            err_len_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_len_q <= hs && !len_ok;
            // Engine inputs only change on a pop, which can only happen in IDLE.
            if (pop) begin
                eng_strand_q <= strand_mem[rd_ptr_q[AW-1:0]];
                eng_n_q      <= len_mem[rd_ptr_q[AW-1:0]];
                res_tag_q    <= tag_mem[rd_ptr_q[AW-1:0]];
            end
            if (complete) jobs_done_q <= jobs_done_q + 16'd1;
        end
    end

    assign eng_start  = (state_q == LAUNCH);
    assign res_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE) || !fifo_empty;
    assign eng_strand = eng_strand_q;
    assign eng_N      = eng_n_q;
    assign res_tag    = res_tag_q;
    assign jobs_done  = jobs_done_q;
    assign err_len    = err_len_q;

endmodule

// File: tb/tb_soft_recursion_scheduler.sv
// Directed self-checking bench for soft_recursion_scheduler.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.

module tb_soft_recursion_scheduler;

`ifdef SOFT_REC_WATCHDOG_EN
    localparam int TOC = 64;
    logic timeout;
`else
    localparam int TOC = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_strand = '0;
    logic [31:0] in_len = '0;
    logic [3:0]  in_tag = '0;
    logic        eng_start;
    logic [31:0] eng_strand;
    logic [31:0] eng_N;
    logic        eng_done = 1'b0;
    logic        res_valid;
    logic [3:0]  res_tag;
    logic        res_ack = 1'b0;
    logic        err_len;
    logic        busy;
    logic [15:0] jobs_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    soft_recursion_scheduler #(
        .DATA_WIDTH(32), .n(10), .FIFO_DEPTH(4), .TAG_WIDTH(4), .TIMEOUT_CYCLES(TOC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_strand(in_strand), .in_len(in_len), .in_tag(in_tag),
        .eng_start(eng_start), .eng_strand(eng_strand), .eng_N(eng_N),
        .eng_done(eng_done),
        .res_valid(res_valid), .res_tag(res_tag), .res_ack(res_ack),
        .err_len(err_len), .busy(busy), .jobs_done(jobs_done)
`ifdef SOFT_REC_WATCHDOG_EN
        , .timeout(timeout)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one job for exactly one handshake edge.
    task automatic offer(input logic [31:0] s, input logic [31:0] l, input logic [3:0] t);
        chk("offer_ready", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_strand = s;
        in_len    = l;
        in_tag    = t;
        tick;
        in_valid  = 1'b0;
    endtask

    // Wait (bounded) for eng_start; also checks how many edges it took.
    task automatic wait_launch(input string tag, input int exp_wait);
        int w = 0;
        while (eng_start !== 1'b1 && w < 20) begin
            tick;
            w++;
        end
        chk({tag, "_start"}, {31'd0, eng_start}, 32'd1);
        chk({tag, "_latency"}, w, exp_wait);
    endtask

    // Called in the LAUNCH cycle: runs the job to completion and acks it.
    task automatic finish_job(input logic [3:0] t, input logic [31:0] l, input logic [15:0] jd);
        tick;
        chk("fj_start_once", {31'd0, eng_start}, 32'd0);
        tick;
        chk("fj_no_early_valid", {31'd0, res_valid}, 32'd0);
        eng_done = 1'b1;
        tick;
        chk("fj_valid", {31'd0, res_valid}, 32'd1);
        chk("fj_tag", {28'd0, res_tag}, {28'd0, t});
        chk("fj_len", eng_N, l);
        chk("fj_jobs_done", {16'd0, jobs_done}, {16'd0, jd});
        eng_done = 1'b0;
        res_ack  = 1'b1;
        tick;
        res_ack  = 1'b0;
        chk("fj_valid_clr", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        int bad;

        // ---------- reset values ----------
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_eng_start", {31'd0, eng_start}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_err_len", {31'd0, err_len}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_jobs_done", {16'd0, jobs_done}, 32'd0);
        chk("rst_eng_N", eng_N, 32'd0);
        chk("rst_eng_strand", eng_strand, 32'd0);
        chk("rst_res_tag", {28'd0, res_tag}, 32'd0);
        #20;
        rst_n = 1'b1;
        tick;

        // ---------- single job, done 40 cycles after start ----------
        offer(32'hA5A5_0F0F, 32'd12, 4'd3);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        chk("t1_no_start_yet", {31'd0, eng_start}, 32'd0);
        wait_launch("t1", 1);
        chk("t1_eng_N", eng_N, 32'd12);
        chk("t1_eng_strand", eng_strand, 32'hA5A5_0F0F);
        chk("t1_res_tag", {28'd0, res_tag}, 32'd3);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (eng_start !== 1'b0 || res_valid !== 1'b0 || eng_N !== 32'd12 ||
                eng_strand !== 32'hA5A5_0F0F)
                bad++;
        end
        chk("t1_stable_run", bad, 0);
        eng_done = 1'b1;
        tick;
        chk("t1_res_valid", {31'd0, res_valid}, 32'd1);
        chk("t1_res_tag_out", {28'd0, res_tag}, 32'd3);
        chk("t1_jobs_done", {16'd0, jobs_done}, 32'd1);
        tick;
        tick;
        tick;
        chk("t1_hold_valid", {31'd0, res_valid}, 32'd1);
        chk("t1_hold_N", eng_N, 32'd12);
        res_ack = 1'b1;
        tick;
        res_ack = 1'b0;
        chk("t1_ack_valid", {31'd0, res_valid}, 32'd0);
        chk("t1_ack_busy", {31'd0, busy}, 32'd0);
        chk("t1_jobs_after", {16'd0, jobs_done}, 32'd1);

        // ---------- stale done (eng_done still 1) ----------
        offer(32'h1234_5678, 32'd20, 4'd5);
        wait_launch("t2", 1);
        tick;
        chk("t2_arm_valid", {31'd0, res_valid}, 32'd0);
        tick;
        chk("t2_run_valid", {31'd0, res_valid}, 32'd0);
        eng_done = 1'b0;
        tick;
        chk("t2_run_valid2", {31'd0, res_valid}, 32'd0);
        tick;
        eng_done = 1'b1;
        tick;
        chk("t2_valid", {31'd0, res_valid}, 32'd1);
        chk("t2_tag", {28'd0, res_tag}, 32'd5);
        chk("t2_jobs_done", {16'd0, jobs_done}, 32'd2);
        eng_done = 1'b0;
        res_ack  = 1'b1;
        tick;
        res_ack  = 1'b0;

        // ---------- fill the FIFO behind a running job ----------
        offer(32'h0000_0099, 32'd7, 4'd9);
        wait_launch("t3a", 1);
        for (int t = 0; t < 4; t++) begin
            in_valid  = 1'b1;
            in_strand = 32'(t);
            in_len    = 32'(t + 1);
            in_tag    = 4'(t);
            tick;
        end
        in_strand = 32'd4;
        in_len    = 32'd5;
        in_tag    = 4'd4;
        chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
        tick;
        chk("t3_full_ready2", {31'd0, in_ready}, 32'd0);
        eng_done = 1'b1;
        tick;
        chk("t3_j9_valid", {31'd0, res_valid}, 32'd1);
        chk("t3_j9_tag", {28'd0, res_tag}, 32'd9);
        chk("t3_j9_N", eng_N, 32'd7);
        chk("t3_j9_jobs", {16'd0, jobs_done}, 32'd3);
        eng_done = 1'b0;
        res_ack  = 1'b1;
        tick;
        res_ack  = 1'b0;
        chk("t3_idle_ready", {31'd0, in_ready}, 32'd0);
        tick;
        chk("t3_t0_start", {31'd0, eng_start}, 32'd1);
        chk("t3_t0_tag", {28'd0, res_tag}, 32'd0);
        chk("t3_t0_N", eng_N, 32'd1);
        chk("t3_slot_free", {31'd0, in_ready}, 32'd1);
        tick;
        in_valid = 1'b0;
        tick;
        eng_done = 1'b1;
        tick;
        chk("t3_t0_valid", {31'd0, res_valid}, 32'd1);
        chk("t3_t0_res_tag", {28'd0, res_tag}, 32'd0);
        chk("t3_t0_jobs", {16'd0, jobs_done}, 32'd4);
        eng_done = 1'b0;
        res_ack  = 1'b1;
        tick;
        res_ack  = 1'b0;
        for (int t = 1; t < 5; t++) begin
            wait_launch("t3_next", 1);
            finish_job(4'(t), 32'(t + 1), 16'(4 + t));
        end
        chk("t3_busy_end", {31'd0, busy}, 32'd0);

        // ---------- illegal lengths ----------
        in_valid  = 1'b1;
        in_strand = 32'hDEAD_BEEF;
        in_len    = 32'd0;
        in_tag    = 4'd7;
        chk("t4_ready", {31'd0, in_ready}, 32'd1);
        tick;
        in_len = 32'd33;
        chk("t4_err1", {31'd0, err_len}, 32'd1);
        tick;
        in_valid = 1'b0;
        chk("t4_err2", {31'd0, err_len}, 32'd1);
        tick;
        chk("t4_err_clr", {31'd0, err_len}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_no_start", {31'd0, eng_start}, 32'd0);
        offer(32'h1, 32'd31, 4'd7);
        chk("t4_err_3n", {31'd0, err_len}, 32'd1);
        chk("t4_busy_3n", {31'd0, busy}, 32'd0);
        offer(32'h2, 32'd30, 4'd2);
        wait_launch("t4_max", 1);
        finish_job(4'd2, 32'd30, 16'd9);

        // ---------- reset mid-RUN with 2 queued ----------
        offer(32'h0000_CAFE, 32'd5, 4'd1);
        wait_launch("t5", 1);
        in_valid  = 1'b1;
        in_strand = 32'h2;
        in_len    = 32'd6;
        in_tag    = 4'd2;
        tick;
        in_strand = 32'h3;
        in_len    = 32'd7;
        in_tag    = 4'd3;
        tick;
        in_valid = 1'b0;
        tick;
        chk("t5_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_start", {31'd0, eng_start}, 32'd0);
        chk("t5_rst_N", eng_N, 32'd0);
        chk("t5_rst_strand", eng_strand, 32'd0);
        chk("t5_rst_tag", {28'd0, res_tag}, 32'd0);
        chk("t5_rst_jobs", {16'd0, jobs_done}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        chk("t5_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_rst_valid", {31'd0, res_valid}, 32'd0);
        #10;
        rst_n = 1'b1;
        tick;
        chk("t5_empty", {31'd0, busy}, 32'd0);
        offer(32'h0000_0BAD, 32'd9, 4'd6);
        wait_launch("t5_after", 1);
        chk("t5_after_N", eng_N, 32'd9);
        finish_job(4'd6, 32'd9, 16'd1);

`ifdef SOFT_REC_WATCHDOG_EN
        // ---------- watchdog ----------
        offer(32'h1, 32'd3, 4'd8);
        wait_launch("t6", 1);
        tick;
        repeat (63) tick;
        chk("t6_not_yet", {31'd0, res_valid}, 32'd0);
        tick;
        chk("t6_valid", {31'd0, res_valid}, 32'd1);
        chk("t6_timeout", {31'd0, timeout}, 32'd1);
        chk("t6_jobs", {16'd0, jobs_done}, 32'd1);
        res_ack = 1'b1;
        tick;
        res_ack = 1'b0;
        chk("t6_timeout_clr", {31'd0, timeout}, 32'd0);
        chk("t6_valid_clr", {31'd0, res_valid}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
